// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - funct3 access codes, FSM encoding and legality check for the memory stage
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // True when a memory access cannot be issued: conflicting direction,
  // misaligned half/word, or a size code that does not exist for the direction.
  function automatic logic access_illegal(input logic       is_load,
                                          input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] lo);
    logic bad;
    bad = is_load && is_store;
    case (f3)
      F3_B:    bad = bad;
      F3_H:    bad = bad || lo[0];
      F3_W:    bad = bad || (lo != 2'b00);
      F3_BU:   bad = bad || is_store;
      F3_HU:   bad = bad || is_store || lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/acknowledge bus
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed lane of a read word and extends it
module load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Bring the addressed byte/half down to bit 0, then extend by access size
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'h000000, shifted[7:0]};
      F3_HU:   data = {16'h0000, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: issues loads/stores and registers write-back
module mem_stage
  import riscv_mem_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ALU_result,
  input  logic [31:0] StoreData,
  input  logic [4:0]  rd,
  input  logic        RegWrite,
  input  logic        MemToReg,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  mem_stage_if.master dmem,
  output logic [31:0] wb_ALU_result,
  output logic [31:0] wb_MemReadData,
  output logic [4:0]  wb_rd,
  output logic        wb_RegWrite,
  output logic        wb_MemToReg,
  output logic        mem_err
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  state_e state_q, state_d;

  // Operands captured when a memory access is accepted
  logic [31:0]   addr_q, wdata_q, alu_q;
  logic [3:0]    wstrb_q;
  logic          we_q, regwrite_q, memtoreg_q;
  logic [4:0]    rd_q;
  logic [2:0]    funct3_q;
  logic [CW-1:0] cnt_q;

  logic [31:0] wb_alu_q, wb_mrd_q;
  logic [4:0]  wb_rd_q;
  logic        wb_rw_q, wb_m2r_q, err_q;

  logic        accept, is_mem, illegal, ack_evt, timeout;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata, ld_data;

  assign accept  = in_valid && (state_q == ST_IDLE);
  assign is_mem  = MemRead || MemWrite;
  assign illegal = is_mem && access_illegal(MemRead, MemWrite, funct3, ALU_result[1:0]);
  assign ack_evt = (state_q == ST_ACCESS) && dmem.dmem_ack;
  assign timeout = (state_q == ST_ACCESS) && !dmem.dmem_ack && (cnt_q == LAST_WAIT);

  load_align u_load_align (
    .rdata   (dmem.dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .data    (ld_data)
  );

  // Store byte enables and lane-replicated data for the incoming entry
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = StoreData;
    case (funct3)
      F3_B: begin
        st_wstrb = 4'b0001 << ALU_result[1:0];
        st_wdata = {4{StoreData[7:0]}};
      end
      F3_H: begin
        st_wstrb = 4'b0011 << ALU_result[1:0];
        st_wdata = {2{StoreData[15:0]}};
      end
      F3_W:    st_wstrb = 4'b1111;
      default: st_wstrb = 4'b0000;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: enter ACCESS on a legal memory entry, leave on ack or wait expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept && is_mem && !illegal) state_d = ST_ACCESS;
      ST_ACCESS: if (ack_evt || timeout)           state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: request lines are only live in ACCESS and come straight from latched operands
  always_comb begin
    in_ready        = 1'b0;
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_wstrb = 4'b0000;
    dmem.dmem_addr  = {addr_q[31:2], 2'b00};
    dmem.dmem_wdata = wdata_q;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_ACCESS: begin
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = we_q;
        dmem.dmem_wstrb = wstrb_q;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Operand latch, wait counter, write-back registers and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      alu_q      <= '0;
      wstrb_q    <= '0;
      we_q       <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      rd_q       <= '0;
      funct3_q   <= '0;
      cnt_q      <= '0;
      wb_alu_q   <= '0;
      wb_mrd_q   <= '0;
      wb_rd_q    <= '0;
      wb_rw_q    <= 1'b0;
      wb_m2r_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Any cycle that does not write back leaves a bubble with fields held
      wb_rw_q <= 1'b0;
      err_q   <= 1'b0;

      if ((state_q == ST_ACCESS) && (state_d == ST_ACCESS)) cnt_q <= cnt_q + CW'(1);
      else                                                  cnt_q <= '0;

      if (accept) begin
        if (!is_mem) begin
          wb_alu_q <= ALU_result;
          wb_mrd_q <= '0;
          wb_rd_q  <= rd;
          wb_rw_q  <= RegWrite;
          wb_m2r_q <= MemToReg;
        end else if (illegal) begin
          err_q <= 1'b1;
        end else begin
          addr_q     <= ALU_result;
          wdata_q    <= st_wdata;
          wstrb_q    <= MemWrite ? st_wstrb : 4'b0000;
          we_q       <= MemWrite;
          alu_q      <= ALU_result;
          regwrite_q <= RegWrite;
          memtoreg_q <= MemToReg;
          rd_q       <= rd;
          funct3_q   <= funct3;
        end
      end

      if (ack_evt) begin
        wb_alu_q <= alu_q;
        wb_mrd_q <= we_q ? 32'h0 : ld_data;
        wb_rd_q  <= rd_q;
        wb_rw_q  <= regwrite_q;
        wb_m2r_q <= memtoreg_q;
      end

      if (timeout) err_q <= 1'b1;
    end
  end

  assign wb_ALU_result  = wb_alu_q;
  assign wb_MemReadData = wb_mrd_q;
  assign wb_rd          = wb_rd_q;
  assign wb_RegWrite    = wb_rw_q;
  assign wb_MemToReg    = wb_m2r_q;
  assign mem_err        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage
module tb_mem_stage;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ALU_result, StoreData;
  logic [4:0]  rd;
  logic        RegWrite, MemToReg, MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] wb_ALU_result, wb_MemReadData;
  logic [4:0]  wb_rd;
  logic        wb_RegWrite, wb_MemToReg, mem_err;

  mem_stage_if bus ();

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ALU_result     (ALU_result),
    .StoreData      (StoreData),
    .rd             (rd),
    .RegWrite       (RegWrite),
    .MemToReg       (MemToReg),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .funct3         (funct3),
    .dmem           (bus),
    .wb_ALU_result  (wb_ALU_result),
    .wb_MemReadData (wb_MemReadData),
    .wb_rd          (wb_rd),
    .wb_RegWrite    (wb_RegWrite),
    .wb_MemToReg    (wb_MemToReg),
    .mem_err        (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mrd;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
  } wb_t;

  wb_t sb[$];
  wb_t last_wb;
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_wb(input logic [31:0] alu, input logic [31:0] mrd, input logic [4:0] r,
                         input logic rw, input logic m2r);
    wb_t e;
    e.alu = alu; e.mrd = mrd; e.rd = r; e.rw = rw; e.m2r = m2r;
    sb.push_back(e);
  endtask

  task automatic check_wb(input string tag);
    wb_t e;
    e = sb.pop_front();
    chk({tag, " wb_ALU_result"}, wb_ALU_result, e.alu);
    chk({tag, " wb_MemReadData"}, wb_MemReadData, e.mrd);
    chk({tag, " wb_rd"}, 32'(wb_rd), 32'(e.rd));
    chk({tag, " wb_RegWrite"}, 32'(wb_RegWrite), 32'(e.rw));
    chk({tag, " wb_MemToReg"}, 32'(wb_MemToReg), 32'(e.m2r));
    last_wb = e;
  endtask

  task automatic check_bubble(input string tag);
    chk({tag, " bubble wb_RegWrite"}, 32'(wb_RegWrite), 32'd0);
    chk({tag, " held wb_rd"}, 32'(wb_rd), 32'(last_wb.rd));
    chk({tag, " held wb_ALU_result"}, wb_ALU_result, last_wb.alu);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " dmem_req"}, 32'(bus.dmem_req), 32'd0);
    chk({tag, " dmem_we"}, 32'(bus.dmem_we), 32'd0);
    chk({tag, " dmem_wstrb"}, 32'(bus.dmem_wstrb), 32'd0);
    chk({tag, " wb_ALU_result"}, wb_ALU_result, 32'd0);
    chk({tag, " wb_MemReadData"}, wb_MemReadData, 32'd0);
    chk({tag, " wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, " wb_RegWrite"}, 32'(wb_RegWrite), 32'd0);
    chk({tag, " wb_MemToReg"}, 32'(wb_MemToReg), 32'd0);
    chk({tag, " mem_err"}, 32'(mem_err), 32'd0);
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] r,
                        input logic rw, input logic m2r, input logic mr, input logic mw,
                        input logic [2:0] f3);
    ALU_result = alu; StoreData = sd; rd = r; RegWrite = rw; MemToReg = m2r;
    MemRead = mr; MemWrite = mw; funct3 = f3; in_valid = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input string tag, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] r, input logic rw, input logic m2r, input logic mr,
                       input logic mw, input logic [2:0] f3);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    set_op(alu, sd, r, rw, m2r, mr, mw, f3);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic nonmem(input string tag, input logic [31:0] alu, input logic [4:0] r,
                        input logic rw, input logic m2r);
    push_wb(alu, 32'h0, r, rw, m2r);
    issue(tag, alu, 32'h0, r, rw, m2r, 1'b0, 1'b0, 3'b111);
    check_wb(tag);
  endtask

  // Memory responder: acknowledges on the ack_at-th request cycle (0 = never)
  task automatic serve(input string tag, input int ack_at, input logic [31:0] word,
                       input logic [31:0] exp_addr, input logic exp_we,
                       input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                       output int reqs);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.dmem_req !== 1'b1) break;
      reqs++;
      chk({tag, " dmem_addr"}, bus.dmem_addr, exp_addr);
      chk({tag, " dmem_we"}, 32'(bus.dmem_we), 32'(exp_we));
      if (exp_we) begin
        chk({tag, " dmem_wstrb"}, 32'(bus.dmem_wstrb), 32'(exp_wstrb));
        chk({tag, " dmem_wdata"}, bus.dmem_wdata, exp_wdata);
      end
      if (reqs == ack_at) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = word;
      end
      @(negedge clk);
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = 32'h0;
      if (reqs == ack_at) break;
    end
  endtask

  task automatic mem_op(input string tag, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] r, input logic rw, input logic m2r, input logic mr,
                        input logic mw, input logic [2:0] f3, input int ack_at,
                        input logic [31:0] word, input logic [31:0] exp_mrd, input int exp_reqs,
                        input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
    int reqs;
    if (ack_at > 0) push_wb(addr, exp_mrd, r, rw, m2r);
    issue(tag, addr, sd, r, rw, m2r, mr, mw, f3);
    serve(tag, ack_at, word, {addr[31:2], 2'b00}, mw, exp_wstrb, exp_wdata, reqs);
    chk({tag, " req_cycles"}, 32'(reqs), 32'(exp_reqs));
    chk({tag, " dmem_req_done"}, 32'(bus.dmem_req), 32'd0);
    if (ack_at > 0) begin
      check_wb(tag);
    end else begin
      chk({tag, " timeout mem_err"}, 32'(mem_err), 32'd1);
      check_bubble(tag);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    in_valid = 1'b0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
    last_wb = '{32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Non-memory op, then an idle cycle must leave a bubble with fields held
    nonmem("alu_op", 32'h1234, 5'd5, 1'b1, 1'b0);
    chk("alu_op in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_bubble("idle_after_alu");

    mem_op("lb_103", 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, F3_B, 3, 32'h80FF_FF00,
           32'hFFFF_FF80, 3, 4'b0000, 32'h0);
    mem_op("sh_22", 32'h22, 32'h0000_ABCD, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, F3_H, 1, 32'h0,
           32'h0, 1, 4'b1100, 32'hABCD_ABCD);
    mem_op("lhu_102", 32'h102, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, F3_HU, 4, 32'h80FF_FF00,
           32'h0000_80FF, 4, 4'b0000, 32'h0);
    mem_op("lh_100", 32'h100, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, F3_H, 2, 32'h1234_8001,
           32'hFFFF_8001, 2, 4'b0000, 32'h0);
    mem_op("lbu_101", 32'h101, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, F3_BU, 1, 32'h0000_A500,
           32'h0000_00A5, 1, 4'b0000, 32'h0);
    mem_op("lw_104", 32'h104, 32'h0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, F3_W, 1, 32'hCAFE_F00D,
           32'hCAFE_F00D, 1, 4'b0000, 32'h0);
    mem_op("sb_41", 32'h41, 32'h1234_56C3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, F3_B, 2, 32'h0,
           32'h0, 2, 4'b0010, 32'hC3C3_C3C3);
    mem_op("sw_80", 32'h80, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, F3_W, 1, 32'h0,
           32'h0, 1, 4'b1111, 32'hDEAD_BEEF);

    // Misaligned LW: no request, error pulse, next entry accepted back-to-back
    chk("lw_6 in_ready", 32'(in_ready), 32'd1);
    set_op(32'h6, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, F3_W);
    @(negedge clk);
    chk("lw_6 dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("lw_6 mem_err", 32'(mem_err), 32'd1);
    check_bubble("lw_6");
    chk("lw_6 in_ready_after", 32'(in_ready), 32'd1);
    push_wb(32'h55, 32'h0, 5'd9, 1'b1, 1'b0);
    set_op(32'h55, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    in_valid = 1'b0;
    chk("after_lw_6 mem_err", 32'(mem_err), 32'd0);
    check_wb("after_lw_6");

    // Read and write together, and a nonexistent load size, are both rejected
    set_op(32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, F3_W);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rw_both dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("rw_both mem_err", 32'(mem_err), 32'd1);
    check_bubble("rw_both");
    set_op(32'h0, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 3'b110);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bad_f3 dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("bad_f3 mem_err", 32'(mem_err), 32'd1);
    check_bubble("bad_f3");

    // No acknowledge: request held for MAX_WAIT cycles then abandoned
    mem_op("timeout", 32'h200, 32'h0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, F3_W, 0, 32'h0,
           32'h0, 4, 4'b0000, 32'h0);
    chk("timeout in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("timeout mem_err_once", 32'(mem_err), 32'd0);

    // A stray acknowledge while idle has no effect
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
    chk("stray_ack dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("stray_ack in_ready", 32'(in_ready), 32'd1);
    check_bubble("stray_ack");

    // Reset in the middle of an access drops it
    issue("rst_mid", 32'h300, 32'h0, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0, F3_W);
    chk("rst_mid dmem_req", 32'(bus.dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst in_ready", 32'(in_ready), 32'd1);
    chk("post_rst dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("post_rst wb_RegWrite", 32'(wb_RegWrite), 32'd0);
    nonmem("post_rst_alu", 32'hA5A5_0001, 5'd31, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 255, the maximum cycles to wait for dmem_ack before aborting.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX/MEM entry present.
- in_ready  out  1  block can accept an entry.
- ALU_result  in  32  address or ALU value.
- StoreData  in  32  rs2 value for stores.
- rd  in  5  destination register.
- RegWrite  in  1  write-back request.
- MemToReg  in  1  select load data at write-back.
- MemRead  in  1  load.
- MemWrite  in  1  store.
- funct3  in  3  access size/sign.
- dmem_req  out  1  memory request.
- dmem_we  out  1  store when 1.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_wstrb  out  4  byte enables.
- dmem_ack  in  1  request done; dmem_rdata valid this cycle.
- dmem_rdata  in  32  read word.
- wb_ALU_result  out  32  registered to write-back.
- wb_MemReadData  out  32  registered, extended load data.
- wb_rd  out  5  registered.
- wb_RegWrite  out  1  registered; 0 means bubble.
- wb_MemToReg  out  1  registered.
- mem_err  out  1  one-cycle error pulse.

Function
REQ-003 FSM states SHALL be IDLE and ACCESS; in_ready = (state==IDLE); a transfer occurs when in_valid && in_ready.
REQ-004 A non-memory transfer (MemRead=MemWrite=0) SHALL load the wb_* registers at the same edge with wb_RegWrite=RegWrite and wb_MemReadData=0, giving 1-cycle latency, and SHALL stay in IDLE.
REQ-005 A legal memory transfer SHALL latch the operands, go to ACCESS, and drive dmem_req=1 with stable dmem_* from the next cycle until and including the dmem_ack cycle.
REQ-006 In ACCESS with dmem_ack=1, the block SHALL load the wb_* registers at that edge and return to IDLE; wb_MemReadData SHALL be the extended load value for loads and 0 for stores.
REQ-007 Load extension by funct3, selecting the lane by addr[1:0]:
- 000 LB: sign-extend byte.
- 001 LH: sign-extend half.
- 010 LW: full word.
- 100 LBU: zero-extend byte.
- 101 LHU: zero-extend half.
REQ-008 Store strobes and data:
- SB: wstrb=4'b0001<<addr[1:0], data byte replicated x4.
- SH: wstrb=4'b0011<<addr[1:0], data half replicated x2.
- SW: wstrb=4'b1111.
REQ-009 The access SHALL be illegal, with no dmem request, wb_RegWrite=0 at the accept edge, mem_err pulsed the next cycle, and the state staying IDLE, when any of these holds:
- halfword with addr[0]=1;
- word with addr[1:0]!=0;
- unlisted funct3;
- MemRead && MemWrite.
REQ-010 If dmem_ack does not arrive within MAX_WAIT cycles of the first dmem_req, the block SHALL deassert dmem_req, write a bubble (wb_RegWrite=0), pulse mem_err, and return to IDLE.
REQ-011 Every cycle without a write into wb_* (in_valid=0, or waiting in ACCESS) SHALL load wb_RegWrite=0 with the other wb_* fields held.
REQ-012 dmem_ack received while in IDLE SHALL be ignored.

Reset
REQ-013 While rst=1 the block SHALL hold state=IDLE, dmem_req=0, dmem_we=0, dmem_wstrb=0, all wb_* outputs=0, mem_err=0, and the wait counter=0, asynchronously.
REQ-014 Reset asserted during ACCESS SHALL abandon the access with no write-back; in_ready=1 on the first cycle after release.

Structure
REQ-015 Package riscv_mem_pkg SHALL hold the funct3 load/store constants and the FSM state encoding.
REQ-016 Load lane select and extension SHALL be a sub-module load_align (rdata, addr_lo, funct3 -> data).

Verification
REQ-017 Non-memory op: ALU_result=0x1234, rd=5, RegWrite=1 -> next cycle wb_ALU_result=0x1234, wb_rd=5, wb_RegWrite=1, in_ready stays 1.
REQ-018 LB at addr 0x103, dmem_rdata=0x80FF_FF00, ack after 3 cycles -> dmem_addr=0x100, dmem_req held 3 cycles, wb_MemReadData=0xFFFF_FF80, wb_MemToReg=1.
REQ-019 SH at addr 0x22, StoreData=0xABCD -> dmem_we=1, wstrb=4'b1100, wdata=0xABCD_ABCD, wb_RegWrite=0 after ack.
REQ-020 LW at addr 0x6 -> no dmem_req, mem_err=1 for one cycle, wb_RegWrite=0, next op accepted immediately.
REQ-021 MAX_WAIT=4, no ack -> dmem_req drops after 4 cycles, mem_err pulses, bubble written; rst mid-ACCESS -> all outputs 0, in_ready=1 after release.
